// File: rtl/frame_pkg.sv
// Shared frame geometry, widths and scan FSM states for the frame scan path.
package frame_pkg;

   localparam int FRAME_W      = 320;
   localparam int FRAME_H      = 240;
   localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
   localparam int ADDR_W       = 17;
   localparam int PIX_W        = 12;
   localparam int X_W          = 9;
   localparam int Y_W          = 8;
   localparam int CNT_W        = 16;

   // Address presented outside the active scan (one past the last pixel).
   localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(FRAME_PIXELS);

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      SCAN,
      DRAIN,
      BLANK
   } state_t;

endpackage

// File: rtl/frame_rd_pipe.sv
// Delay line carrying {valid, address} alongside the BRAM read so that the
// address pops out in the same cycle as the data it fetched.
module frame_rd_pipe
   import frame_pkg::*;
#(
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              valid_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o
);

   logic [RD_LATENCY-1:0]             vld_pipe;
   logic [RD_LATENCY-1:0][ADDR_W-1:0] addr_pipe;

   // Shift register; reset flushes every in-flight read.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         vld_pipe  <= '0;
         addr_pipe <= '0;
      end else begin
         vld_pipe[0]  <= valid_i;
         addr_pipe[0] <= addr_i;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
         end
      end
   end

   assign valid_o = vld_pipe[RD_LATENCY-1];
   assign addr_o  = addr_pipe[RD_LATENCY-1];

endmodule

// File: rtl/frame_scan_generator.sv
// Walks the frame buffer once per frame and emits an aligned
// {vsync, address, frame_pixel, x, y} stream for the marker detectors.
module frame_scan_generator
   import frame_pkg::*;
#(
   parameter int H_ACTIVE     = FRAME_W,
   parameter int V_ACTIVE     = FRAME_H,
   parameter int VSYNC_CYCLES = 4,
   parameter int BLANK_CYCLES = 16,
   parameter int RD_LATENCY   = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic              pix_tick,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [PIX_W-1:0]  bram_dout,
   output logic              vsync,
   output logic [ADDR_W-1:0] address,
   output logic [PIX_W-1:0]  frame_pixel,
   output logic              pixel_valid,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_count
);

   localparam logic [ADDR_W-1:0] END_A     = ADDR_W'(H_ACTIVE * V_ACTIVE);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic [X_W-1:0]    X_LAST    = X_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0]  VS_LAST   = CNT_W'(VSYNC_CYCLES - 1);
   localparam logic [CNT_W-1:0]  BL_LAST   = CNT_W'(BLANK_CYCLES - 1);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [ADDR_W-1:0]  rd_ptr_q;
   logic               bram_en_q, vsync_q, frame_done_q;
   logic [ADDR_W-1:0]  bram_addr_q;
   logic [CNT_W-1:0]   frame_count_q;

   logic [ADDR_W-1:0]  address_q;
   logic [PIX_W-1:0]   frame_pixel_q;
   logic               pixel_valid_q;
   logic [X_W-1:0]     x_q, col_q;
   logic [Y_W-1:0]     y_q, row_q;

   logic               pipe_vld;
   logic [ADDR_W-1:0]  pipe_addr;
   logic               last_out;

   // The final pixel of the frame is on the outputs this cycle.
   assign last_out = (state_q == DRAIN) && pixel_valid_q && (address_q == LAST_ADDR);

   frame_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_pipe (
      .clk     (clk),
      .resetn  (resetn),
      .valid_i (bram_en_q),
      .addr_i  (bram_addr_q),
      .valid_o (pipe_vld),
      .addr_o  (pipe_addr)
   );

   // Frame sequencer: vsync, read issue, drain, blanking, frame accounting.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rd_ptr_q      <= '0;
         bram_en_q     <= 1'b0;
         bram_addr_q   <= '0;
         vsync_q       <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         bram_en_q    <= 1'b0;
         frame_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               vsync_q     <= 1'b0;
               bram_addr_q <= '0;
               if (enable) begin
                  state_q <= VSYNC;
                  vsync_q <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            VSYNC: begin
               rd_ptr_q <= '0;
               if (cnt_q == VS_LAST) begin
                  vsync_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= SCAN;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            SCAN: begin
               if (pix_tick) begin
                  bram_en_q   <= 1'b1;
                  bram_addr_q <= rd_ptr_q;
                  rd_ptr_q    <= rd_ptr_q + 17'd1;
                  if (rd_ptr_q == LAST_ADDR) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_out) begin
                  frame_done_q  <= 1'b1;
                  frame_count_q <= frame_count_q + 16'd1;
                  cnt_q         <= '0;
                  state_q       <= BLANK;
               end
            end
            BLANK: begin
               if (cnt_q == BL_LAST) begin
                  cnt_q <= '0;
                  if (enable) begin
                     state_q <= VSYNC;
                     vsync_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Output stage: capture data with its delayed address and step x/y.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         address_q     <= END_A;
         frame_pixel_q <= '0;
         pixel_valid_q <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         col_q         <= '0;
         row_q         <= '0;
      end else begin
         pixel_valid_q <= 1'b0;
         if (state_q == VSYNC) begin
            col_q <= '0;
            row_q <= '0;
         end
         if (state_q == IDLE) begin
            frame_pixel_q <= '0;
            x_q           <= '0;
            y_q           <= '0;
         end
         if (pipe_vld) begin
            address_q     <= pipe_addr;
            frame_pixel_q <= bram_dout;
            pixel_valid_q <= 1'b1;
            x_q           <= col_q;
            y_q           <= row_q;
            if (col_q == X_LAST) begin
               col_q <= '0;
               row_q <= row_q + 8'd1;
            end else begin
               col_q <= col_q + 9'd1;
            end
         end
         if (last_out) address_q <= END_A;
      end
   end

   assign bram_en     = bram_en_q;
   assign bram_addr   = bram_addr_q;
   assign vsync       = vsync_q;
   assign address     = address_q;
   assign frame_pixel = frame_pixel_q;
   assign pixel_valid = pixel_valid_q;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_scan_generator.sv
// Scoreboard bench: instance 0 is the full 320x240 frame with RD_LATENCY=1,
// instance 1 is a 16x6 frame with RD_LATENCY=2 for the short scenarios.
module tb_frame_scan_generator;

   typedef struct packed {
      logic [16:0] a;
      logic [8:0]  x;
      logic [7:0]  y;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   exp_t  expq [2][$];
   int    issq [2][$];
   int    vectors = 0;
   int    errs    = 0;
   int    cyc     = 0;
   int    iss_cnt [2];
   int    pv_cnt  [2];
   int    fd_cnt  [2];
   logic  alt = 1'b0;

   logic        rstn [2];
   logic        en   [2];
   logic        tick [2];
   logic        vs   [2];
   logic        ben  [2];
   logic        pv   [2];
   logic        fd   [2];
   logic [16:0] baddr[2];
   logic [16:0] addr [2];
   logic [11:0] dout [2];
   logic [11:0] fpix [2];
   logic [8:0]  xo   [2];
   logic [7:0]  yo   [2];
   logic [15:0] fc   [2];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int hsz(int g);
      return (g == 0) ? 320 : 16;
   endfunction

   function automatic int npix(int g);
      return (g == 0) ? 76800 : 96;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : inst
         localparam int H   = (g == 0) ? 320 : 16;
         localparam int V   = (g == 0) ? 240 : 6;
         localparam int VS  = (g == 0) ? 4 : 3;
         localparam int BL  = (g == 0) ? 16 : 5;
         localparam int LAT = (g == 0) ? 1 : 2;

         frame_scan_generator #(
            .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_CYCLES(VS),
            .BLANK_CYCLES(BL), .RD_LATENCY(LAT)
         ) dut (
            .clk(clk), .resetn(rstn[g]), .enable(en[g]), .pix_tick(tick[g]),
            .bram_en(ben[g]), .bram_addr(baddr[g]), .bram_dout(dout[g]),
            .vsync(vs[g]), .address(addr[g]), .frame_pixel(fpix[g]),
            .pixel_valid(pv[g]), .x(xo[g]), .y(yo[g]),
            .frame_done(fd[g]), .frame_count(fc[g])
         );

         // BRAM returning addr[11:0] after LAT clocks
         logic [11:0] r1 = '0;
         logic [11:0] r2 = '0;
         logic        tick_smp = 1'b0;
         exp_t        e;
         always @(posedge clk) begin
            tick_smp <= tick[g];
            if (ben[g]) r1 <= baddr[g][11:0];
            r2 <= r1;
         end
         assign dout[g] = (LAT == 1) ? r1 : r2;

         // monitor
         always @(negedge clk) begin
            if (!rstn[g]) begin
               expq[g].delete();
               issq[g].delete();
               iss_cnt[g] = 0;
            end else begin
               if (ben[g]) begin
                  chk("issue_addr", baddr[g], iss_cnt[g] % (H * V));
                  chk("issue_without_tick", tick_smp, 1);
                  issq[g].push_back(cyc);
                  iss_cnt[g]++;
               end
               if (pv[g]) begin
                  pv_cnt[g]++;
                  if (expq[g].size() == 0) begin
                     chk("unexpected_pixel_valid", pv[g], 0);
                  end else begin
                     e = expq[g].pop_front();
                     chk("pix_address", addr[g], e.a);
                     chk("pix_data", fpix[g], e.a[11:0]);
                     chk("pix_x", xo[g], e.x);
                     chk("pix_y", yo[g], e.y);
                     if (issq[g].size() == 0) chk("pixel_without_issue", pv[g], 0);
                     else chk("latency", cyc - issq[g].pop_front(), LAT + 1);
                  end
               end
               if (fd[g]) fd_cnt[g]++;
            end
         end
      end
   endgenerate

   task automatic step();
      @(posedge clk);
      #2;
      if (alt) tick[1] = ~tick[1];
   endtask

   task automatic push_frame(int gi);
      exp_t t;
      for (int i = 0; i < npix(gi); i++) begin
         t.a = 17'(i);
         t.x = 9'(i % hsz(gi));
         t.y = 8'(i / hsz(gi));
         expq[gi].push_back(t);
      end
   endtask

   task automatic wait_fd(int gi, int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         step();
         if (fd[gi]) break;
      end
      chk("frame_done_timeout", fd[gi], 1);
   endtask

   task automatic wait_issue(int gi, int a, int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         if (ben[gi] && baddr[gi] == 17'(a)) break;
         step();
      end
      chk("issue_reach_timeout", ben[gi] && baddr[gi] == 17'(a), 1);
   endtask

   task automatic chk_reset(int gi);
      chk("rst_vsync", vs[gi], 0);
      chk("rst_bram_en", ben[gi], 0);
      chk("rst_bram_addr", baddr[gi], 0);
      chk("rst_address", addr[gi], npix(gi));
      chk("rst_pixel", fpix[gi], 0);
      chk("rst_pixel_valid", pv[gi], 0);
      chk("rst_x", xo[gi], 0);
      chk("rst_y", yo[gi], 0);
      chk("rst_frame_done", fd[gi], 0);
      chk("rst_frame_count", fc[gi], 0);
   endtask

   initial begin
      int n, m, t1, t2, base;
      for (int i = 0; i < 2; i++) begin
         rstn[i] = 1'b0; en[i] = 1'b0; tick[i] = 1'b0;
         pv_cnt[i] = 0; fd_cnt[i] = 0; iss_cnt[i] = 0;
      end
      repeat (3) step();
      chk_reset(0);
      chk_reset(1);
      rstn[0] = 1'b1; rstn[1] = 1'b1;
      step();

      // full default frame, enable dropped mid-scan at address 1000
      push_frame(0);
      tick[0] = 1'b1; en[0] = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (vs[0]) n++;
      end
      chk("vsync_len", n, 4);
      wait_issue(0, 1000, 3000);
      en[0] = 1'b0;
      wait_fd(0, 80000);
      chk("f0_frame_count", fc[0], 1);
      chk("f0_done_address", addr[0], 76800);
      chk("f0_last_x", xo[0], 319);
      chk("f0_last_y", yo[0], 239);
      n = 0; m = 0;
      for (int i = 0; i < 26; i++) begin
         step();
         if (addr[0] == 17'd76800) n++;
         if (vs[0]) m++;
      end
      chk("f0_blank_end_addr", n, 26);
      chk("f0_vsync_after_disable", m, 0);
      chk("f0_pixel_count", pv_cnt[0], 76800);
      chk("f0_done_count", fd_cnt[0], 1);
      chk("f0_queue_left", expq[0].size(), 0);

      // small frame, lat 2, tick every other cycle, two frames back-to-back
      base = pv_cnt[1];
      push_frame(1); push_frame(1);
      alt = 1'b1; en[1] = 1'b1;
      wait_fd(1, 1000);
      t1 = cyc;
      repeat (20) step();
      en[1] = 1'b0;
      wait_fd(1, 1000);
      t2 = cyc;
      chk("f1_period_about_2x", (t2 - t1 >= 192) && (t2 - t1 <= 215), 1);
      chk("f1_frame_count", fc[1], 2);
      chk("f1_pixel_count", pv_cnt[1] - base, 192);
      chk("f1_queue_left", expq[1].size(), 0);
      n = 0; m = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (addr[1] == 17'd96) n++;
         if (vs[1]) m++;
      end
      chk("f1_blank_end_addr", n, 15);
      chk("f1_vsync_after_disable", m, 0);
      alt = 1'b0; tick[1] = 1'b0;

      // reset mid-scan at address 50
      push_frame(1);
      tick[1] = 1'b1; en[1] = 1'b1;
      step();
      wait_issue(1, 50, 200);
      rstn[1] = 1'b0;
      step();
      chk_reset(1);
      step();
      chk("rst_hold_pixel_valid", pv[1], 0);
      push_frame(1);
      rstn[1] = 1'b1;
      n = 0; m = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (vs[1]) n++;
         if (pv[1]) m++;
      end
      chk("rr_vsync_len", n, 3);
      chk("rr_no_stale_pixel", m, 0);
      wait_fd(1, 400);
      chk("rr_frame_count", fc[1], 1);
      chk("rr_queue_left", expq[1].size(), 0);
      en[1] = 1'b0;
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
